// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register for a 5-stage RV32I core with
//             load-use hazard detection, flush/hold handling and a
//             saturating bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // decode-stage inputs
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic             id_MemRead,
    input  logic             id_ALUSrc,
    input  logic             id_MemToReg,
    input  logic [2:0]       id_ALUOp,
    // pipeline control
    input  logic             flush,
    input  logic             hold,
    // execute-stage outputs
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_MemRead,
    output logic             ex_ALUSrc,
    output logic             ex_MemToReg,
    output logic [2:0]       ex_ALUOp,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_advance;

    // Load in EX whose non-x0 destination is a source actually read by ID.
    always_comb begin
        w_rs1_hit  = id_uses_rs1 & (ex_rd == id_rs1);
        w_rs2_hit  = id_uses_rs2 & (ex_rd == id_rs2);
        w_load_use = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid
                   & (w_rs1_hit | w_rs2_hit);
        // Flush wins so the PC redirect is never blocked; hold freezes
        // everything and defers the hazard decision until it drops.
        stall      = w_load_use & ~flush & ~hold & ~rst;
        w_advance  = ~flush & ~hold & ~w_load_use;
    end

    // Valid and control: cleared on flush or load-use bubble, frozen on hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemToReg <= 1'b0;
            ex_ALUOp    <= 3'b000;
        end else if (flush || (!hold && w_load_use)) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemToReg <= 1'b0;
            ex_ALUOp    <= 3'b000;
        end else if (!hold) begin
            // Control from an empty ID slot is forced to zero.
            ex_valid    <= id_valid;
            ex_RegWrite <= id_valid & id_RegWrite;
            ex_MemWrite <= id_valid & id_MemWrite;
            ex_MemRead  <= id_valid & id_MemRead;
            ex_ALUSrc   <= id_valid & id_ALUSrc;
            ex_MemToReg <= id_valid & id_MemToReg;
            ex_ALUOp    <= id_valid ? id_ALUOp : 3'b000;
        end
    end

    // Data and index fields load only on a normal advance; bubbles keep them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'b000;
        end else if (w_advance) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
        end
    end

    // Count load-use bubbles only; saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (!flush && !hold && w_load_use && (bubble_count != c_CNT_MAX)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Self-checking bench for id_ex_stage with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam logic [7:0] LW  = 8'b1011_1000; // RegWrite MemRead ALUSrc MemToReg
    localparam logic [7:0] ADD = 8'b1000_0000; // RegWrite, ALUOp 000
    localparam logic [7:0] LUI = 8'b1001_0011; // RegWrite ALUSrc, ALUOp 011

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic [2:0]       id_funct3;
    logic [7:0]       id_ctrl;
    logic             id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc, id_MemToReg;
    logic [2:0]       id_ALUOp;
    logic             flush, hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_MemToReg;
    logic [2:0]       ex_ALUOp;
    logic             stall;
    logic [CNT_W-1:0] bubble_count;

    assign id_RegWrite = id_ctrl[7];
    assign id_MemWrite = id_ctrl[6];
    assign id_MemRead  = id_ctrl[5];
    assign id_ALUSrc   = id_ctrl[4];
    assign id_MemToReg = id_ctrl[3];
    assign id_ALUOp    = id_ctrl[2:0];

    int checks = 0;
    int errors = 0;

    // reference model of the EX-side state
    logic             m_valid;
    logic [XLEN-1:0]  m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]       m_rs1, m_rs2, m_rd;
    logic [2:0]       m_f3;
    logic [7:0]       m_ctrl;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct3(id_funct3),
        .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
        .id_MemRead(id_MemRead), .id_ALUSrc(id_ALUSrc),
        .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc),
        .ex_MemToReg(ex_MemToReg), .ex_ALUOp(ex_ALUOp),
        .stall(stall), .bubble_count(bubble_count)
    );

    function automatic logic [156:0] dut_vec();
        return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                ex_rd, ex_funct3, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
                ex_MemToReg, ex_ALUOp, bubble_count};
    endfunction

    function automatic logic [156:0] exp_vec();
        return {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f3,
                m_ctrl, m_cnt};
    endfunction

    // A load sits in EX and ID really reads its (non-zero) destination.
    function automatic logic model_hazard();
        return m_valid && m_ctrl[5] && (m_rd != 5'd0) && id_valid &&
               ((id_uses_rs1 && m_rd == id_rs1) || (id_uses_rs2 && m_rd == id_rs2));
    endfunction

    function automatic logic exp_stall();
        return model_hazard() && !flush && !hold;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_ctrl = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        logic hz;
        hz = model_hazard();
        if (flush) begin
            m_valid = 0; m_ctrl = '0;
        end else if (hold) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 0; m_ctrl = '0;
            if (int'(m_cnt) < (1 << CNT_W) - 1) m_cnt = m_cnt + 1'b1;
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data;
            m_rs2d = id_rs2_data; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_rd = id_rd; m_f3 = id_funct3; m_ctrl = id_valid ? id_ctrl : 8'h00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [7:0] ctrl);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_funct3 = 3'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; hold = 0;
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
        model_reset();
        #3;
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), exp_vec()); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_normal();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);   // lw x5,0(x1)
        #1; checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL normal_stall_lw got=%b exp=%b", stall, exp_stall()); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL normal_lw got=%h exp=%h", dut_vec(), exp_vec()); end
        drive(1'b1, 5'd6, 5'd2, 5'd3, 1'b1, 1'b1, ADD);  // add x6,x2,x3
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL normal_stall_add got=%b exp=0", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL normal_add got=%h exp=%h", dut_vec(), exp_vec()); end
        checks++; if (ex_MemRead !== 1'b0 || bubble_count !== 2'd0) begin errors++; $display("FAIL normal_memread_cnt got=%b/%0d exp=0/0", ex_MemRead, bubble_count); end
        drive(1'b0, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 8'hFF);  // empty slot with junk control
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL normal_invalid got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
        tick();
        drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, ADD);  // add x6,x5,x7
        #1; checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL lu_bubble got=%h exp=%h", dut_vec(), exp_vec()); end
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%b exp=0", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL lu_advance got=%h exp=%h", dut_vec(), exp_vec()); end
        checks++; if (ex_valid !== 1'b1 || ex_RegWrite !== 1'b1 || ex_ALUOp !== 3'b000 || bubble_count !== 2'd1) begin
            errors++; $display("FAIL lu_add_fields got=%b%b%b cnt=%0d exp=110 cnt=1", ex_valid, ex_RegWrite, ex_ALUOp != 0, bubble_count); end
    endtask

    task automatic test_x0_unused();
        drive(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, LW);   // lw x0
        tick();
        drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, ADD);  // add x6,x0,x0
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b exp=0", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL x0_flow got=%h exp=%h", dut_vec(), exp_vec()); end
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);   // lw x5
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, LUI);  // lui x5 (no sources)
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%b exp=0", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL unused_flow got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
        tick();
        drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, ADD);
        flush = 1;
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        flush = 0;
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL flush_bubble got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_hold();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
        tick();
        drive(1'b1, 5'd8, 5'd2, 5'd5, 1'b1, 1'b1, 8'b0101_0000); // store using x5 as rs2
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=0", i, stall); end
            tick();
            checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL hold_frozen[%0d] got=%h exp=%h", i, dut_vec(), exp_vec()); end
        end
        hold = 0;
        #1; checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall got=%b exp=1", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL hold_bubble got=%h exp=%h", dut_vec(), exp_vec()); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL hold_advance got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
            tick();
            drive(1'b1, 5'd9, 5'd5, 5'd3, 1'b1, 1'b1, ADD);
            tick();
            tick();
            checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL sat_pair[%0d] got=%h exp=%h", i, dut_vec(), exp_vec()); end
        end
        checks++; if (bubble_count !== 2'd3) begin errors++; $display("FAIL sat_count got=%0d exp=3", bubble_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                  1'($urandom), 1'($urandom), 8'($urandom) | (($urandom % 2) ? 8'h20 : 8'h00));
            flush = ($urandom % 8) == 0;
            hold  = ($urandom % 6) == 0;
            #1; checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall[%0d] got=%b exp=%b", i, stall, exp_stall()); end
            tick();
            checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rand_state[%0d] got=%h exp=%h", i, dut_vec(), exp_vec()); end
        end
        flush = 0; hold = 0;
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LW);
        tick();
        drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, ADD);
        #1; checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        rst = 1;
        model_reset();
        #1; checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL mid_reset_outputs got=%h exp=%h", dut_vec(), exp_vec()); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got=%b exp=0", stall); end
        @(negedge clk); rst = 0;
        #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%b exp=0", stall); end
        tick();
        checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL post_reset_load got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_hold();
        test_saturation();
        test_random();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I pipeline, with integrated load-use hazard detection.
- Captures the decode-stage control bits (RegWrite, MemWrite, MemRead, ALUSrc, MemToReg, ALUOp), operands, immediate and register indices every cycle. Presents them registered to EX.
- Detects a load in EX feeding the instruction in ID, stalls PC and IF/ID for one cycle, and injects a bubble into EX.
- Honours branch/jump flush and a global memory hold, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width of pc/operands/immediate.
- CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2.
- id_funct3  in  3  funct3 passthrough (branch compare, load/store size).
- id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc, id_MemToReg  in  1  decoded control.
- id_ALUOp  in  3  decoded ALU operation.
- flush  in  1  branch/jump taken resolved in EX; kill ID instruction.
- hold  in  1  global stall (memory busy); freeze this stage.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_funct3  out  3  registered funct3.
- ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_MemToReg  out  1  registered control.
- ex_ALUOp  out  3  registered ALUOp.
- stall  out  1  combinational; 1 = hold PC and IF/ID this cycle.
- bubble_count  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (async, rst=1): all ex_* outputs 0, ex_valid 0, bubble_count 0. stall = 0 while in reset. Reset asserted mid-stall discards the pending stall. The first edge after deassert performs a normal load.
- Hazard term (combinational):
  - lu = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
  - stall = lu & ~flush & ~hold.
- Per-edge action, priority highest first:
  1. flush=1: bubble. ex_valid and all five control bits and ALUOp become 0. Data/index fields hold. No counter increment. stall=0 so the PC redirect proceeds.
  2. hold=1: every register holds, including ex_valid. Counter holds.
  3. lu=1: bubble as in flush. bubble_count += 1, saturating at 2^CNT_W-1 (no wrap).
  4. Otherwise: load all id_* fields. ex_valid <= id_valid. When id_valid=0, control bits load as 0 regardless of id_* control inputs.
- Latency: 1 cycle ID→EX. A load-use stall costs exactly one bubble. After the bubble, ex_MemRead=0, so lu deasserts and the held instruction advances on the next edge.
- rd = x0 never causes a stall. Store data dependency (rs2 of a store on a load) does stall; no special case.
- Back-to-back loads with a dependency: each dependent pair stalls once; the counter increments per bubble.
- hold with lu true: no bubble is inserted and the counter does not increment. Hazard re-evaluation happens after hold drops.
- Outputs change only on rising clk or async rst. stall is the only combinational output.

Test Plan:
- Normal flow: lw x5,0(x1) followed by add x6,x2,x3 (no dep) → ex_* equal id_* one cycle later, ex_MemRead=1 then 0, stall never 1, bubble_count=0.
- Load-use: lw x5 then add x6,x5,x7 → stall=1 for one cycle, ex_valid=0 with all control 0 in the next cycle, then add enters EX with ex_RegWrite=1, ex_ALUOp=000, bubble_count=1.
- x0 / unused source: lw x0,… then add x6,x0,x0; also lw x5 then lui x5 (id_uses_rs1=0) → stall stays 0, no bubble.
- Flush plus hazard in the same cycle: lw x5 in EX, dependent instruction in ID, flush=1 → stall=0, bubble inserted, bubble_count unchanged.
- Hold: hold=1 for 3 cycles with a hazard pending → all ex_* frozen, stall=0, counter frozen. After hold drops: one bubble, counter +1.
- Reset and saturation: CNT_W=2, drive 5 load-use pairs → bubble_count = 3 and stays 3. Assert rst mid-stall → all outputs 0 asynchronously, stall=0, bubble_count=0.
